// File: rtl/temp_adc_scheduler_if.sv
// Avalon-MM register port, ADC conversion handshake and
// over-temperature alarm for temp_adc_scheduler.
interface temp_adc_scheduler_if;
  logic [2:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        adc_start;
  logic [2:0]  adc_ch;
  logic        adc_done;
  logic [11:0] adc_data;
  logic        overtemp;

  modport slave (
    input  address, write, writedata,
    input  adc_done, adc_data,
    output readdata, adc_start, adc_ch,
    output overtemp
  );

  modport master (
    output address, write, writedata,
    output adc_done, adc_data,
    input  readdata, adc_start, adc_ch,
    input  overtemp
  );
endinterface

// File: rtl/temp_adc_scheduler.sv
// Round-robin averaging scheduler for a shared 12-bit ADC.
// Define TEMP_SCHED_OVERTEMP_EN for threshold + sticky alarm.
module temp_adc_scheduler #(
  parameter int NUM_CH   = 4,
  parameter int AVG_LOG2 = 2,
  parameter int PERIOD   = 50000
) (
  input  logic clk,
  input  logic reset,
  temp_adc_scheduler_if.slave bus
);

  localparam int AW = 12 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam int PW = $clog2(PERIOD);

  localparam logic [CW-1:0] NSMP = CW'(1 << AVG_LOG2);
  localparam logic [PW-1:0] PMAX = PW'(PERIOD - 1);
  localparam logic [2:0]    CH_LAST = 3'(NUM_CH - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_CONV  = 3'd2;
  localparam logic [2:0] S_STORE = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [2:0]    ch_q, ch_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [PW-1:0] per_q, per_d, per_inc;
  logic          en_q, en_d;
  logic          ovr_q, ovr_d, ovr_set;
  logic          abort_q, abort_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [11:0]   res_q [NUM_CH];
  logic [11:0]   res_val;
  logic [11:0]   thr_rd;
  logic          store, busy, alarm;
  logic          wr6, wr7;
  logic          unused_wd;

  assign wr6 = bus.write && (bus.address == 3'd6);
  assign wr7 = bus.write && (bus.address == 3'd7);

  // Disable takes effect in the write cycle itself.
  assign en_d = wr7 ? bus.writedata[0] : en_q;

  assign busy    = (state_q != S_IDLE);
  assign res_val = 12'(acc_q >> AVG_LOG2);
  assign cnt_inc = cnt_q + 1'b1;
  assign per_inc = (per_q == PMAX) ? per_q : per_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    per_d   = per_inc;
    ovr_set = 1'b0;
    store   = 1'b0;
    case (state_q)
      S_IDLE: begin
        per_d   = per_q;
        acc_d   = '0;
        cnt_d   = '0;
        abort_d = 1'b0;
        if (en_q) begin
          per_d   = '0;
          ch_d    = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        state_d = en_d ? S_CONV : S_IDLE;
      end
      S_CONV: begin
        if (!en_d) abort_d = 1'b1;
        if (bus.adc_done) begin
          if (!en_d || abort_q) begin
            acc_d   = '0;
            cnt_d   = '0;
            abort_d = 1'b0;
            state_d = S_IDLE;
          end else begin
            acc_d   = acc_q + AW'(bus.adc_data);
            cnt_d   = cnt_inc;
            state_d = (cnt_inc < NSMP) ? S_START : S_STORE;
          end
        end
      end
      S_STORE: begin
        store = 1'b1;
        acc_d = '0;
        cnt_d = '0;
        if (!en_d) begin
          state_d = S_IDLE;
        end else if (ch_q < CH_LAST) begin
          ch_d    = ch_q + 3'd1;
          state_d = S_START;
        end else begin
          ch_d    = '0;
          state_d = S_WAIT;
          ovr_set = (per_q == PMAX);
        end
      end
      S_WAIT: begin
        if (!en_d) begin
          state_d = S_IDLE;
        end else if (per_q >= PMAX) begin
          per_d   = '0;
          state_d = S_START;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ovr_d = ovr_set | (ovr_q & ~(wr7 & bus.writedata[3]));

  always_comb begin
    rdata_d = '0;
    unique case (1'b1)
      (bus.address == 3'd7):
        rdata_d = {28'd0, ovr_q, alarm, busy, en_q};
      (bus.address == 3'd6):
        rdata_d = {20'd0, thr_rd};
      default:
        for (int i = 0; i < NUM_CH; i++)
          if (bus.address == 3'(i))
            rdata_d = {20'd0, res_q[i]};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      per_q   <= '0;
      en_q    <= 1'b0;
      ovr_q   <= 1'b0;
      abort_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      en_q    <= en_d;
      ovr_q   <= ovr_d;
      abort_q <= abort_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++)
        res_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (store && ch_q == 3'(i))
          res_q[i] <= res_val;
    end
  end

`ifdef TEMP_SCHED_OVERTEMP_EN
  logic [11:0] thr_q;
  logic        alarm_q, alarm_set;

  // A new exceedance outranks a simultaneous W1C.
  assign alarm_set = store && (res_val > thr_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      thr_q   <= 12'hFFF;
      alarm_q <= 1'b0;
    end else begin
      if (wr6) thr_q <= bus.writedata[11:0];
      alarm_q <= alarm_set |
                 (alarm_q & ~(wr7 & bus.writedata[2]));
    end
  end

  assign thr_rd    = thr_q;
  assign alarm     = alarm_q;
  assign unused_wd = ^{bus.writedata[31:12],
                       bus.writedata[1]};
`else
  assign thr_rd    = 12'd0;
  assign alarm     = 1'b0;
  assign unused_wd = ^{bus.writedata[31:4],
                       bus.writedata[2:1], wr6};
`endif

  assign bus.readdata  = rdata_q;
  assign bus.adc_start = (state_q == S_START);
  assign bus.adc_ch    = ch_q;
  assign bus.overtemp  = alarm;

endmodule

// File: tb/tb_temp_adc_scheduler.sv
// Randomized bench for temp_adc_scheduler with an ADC model
// and a sample-level averaging reference.
module tb_temp_adc_scheduler;

  localparam int NCH  = 4;
  localparam int ALOG = 2;
  localparam int PER  = 60;
  localparam int NS   = 1 << ALOG;
`ifdef TEMP_SCHED_OVERTEMP_EN
  localparam bit OT = 1'b1;
`else
  localparam bit OT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  temp_adc_scheduler_if bus();

  temp_adc_scheduler #(
    .NUM_CH(NCH), .AVG_LOG2(ALOG), .PERIOD(PER)
  ) dut (
    .clk(clk), .reset(rst), .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               tag, got, exp);
    end
  endtask

  // ADC model and reference state
  int lat = 1;
  int mode = 0;
  int smp_no = 0;
  int pend = 0;
  int pend_ch = 0;
  bit m_en = 1'b0;
  int exp_ch = 0;
  int grp_n = 0;
  int grp_sum = 0;
  logic [11:0] exp_res [NCH];
  int rounds = 0;
  logic [11:0] m_thr = 12'hFFF;
  bit m_alarm = 1'b0;
  int cyc = 0;
  int last_r0 = 0;
  bit r0_ok = 1'b0;
  int last_per = 0;
  int n_start = 0;
  bit seen_ch2 = 1'b0;

  function automatic int exp_period(input int l);
    int r;
    r = NCH * (NS * (l + 1) + 1);
    return (r >= PER) ? r + 1 : PER;
  endfunction

  always @(negedge clk) begin
    bit eff_en;
    int avg;
    cyc++;
    bus.adc_done = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        bus.adc_done = 1'b1;
        case (mode)
          1: bus.adc_data = 12'(100 + 2 * (smp_no % 4));
          2: bus.adc_data = (pend_ch == 1) ? 12'h201
                                           : 12'h100;
          default: bus.adc_data = 12'($urandom_range(0, 4095));
        endcase
        smp_no++;
      end
    end
    #4;
    eff_en = (bus.write && bus.address == 3'd7)
             ? bus.writedata[0] : m_en;
    if (bus.adc_done && m_en && eff_en) begin
      grp_sum += int'(bus.adc_data);
      grp_n++;
      if (grp_n == NS) begin
        avg = grp_sum / NS;
        exp_res[exp_ch] = 12'(avg);
        if (OT && avg > int'(m_thr)) m_alarm = 1'b1;
        grp_n = 0;
        grp_sum = 0;
        exp_ch++;
        if (exp_ch == NCH) begin
          exp_ch = 0;
          rounds++;
        end
      end
    end
    if (bus.adc_start) begin
      n_start++;
      chk("adc_ch", 32'(bus.adc_ch), 32'(exp_ch));
      if (bus.adc_ch == 3'd2) seen_ch2 = 1'b1;
      if (exp_ch == 0 && grp_n == 0 && m_en) begin
        if (r0_ok) last_per = cyc - last_r0;
        last_r0 = cyc;
        r0_ok = 1'b1;
      end
      pend = lat;
      pend_ch = int'(bus.adc_ch);
    end
    if (bus.write && bus.address == 3'd7) begin
      if (m_en && !bus.writedata[0]) begin
        grp_n = 0;
        grp_sum = 0;
        exp_ch = 0;
        r0_ok = 1'b0;
      end
      if (bus.writedata[2]) m_alarm = 1'b0;
      m_en = bus.writedata[0];
    end
    if (OT && bus.write && bus.address == 3'd6)
      m_thr = bus.writedata[11:0];
  end

  task automatic wr(input logic [2:0] a,
                    input logic [31:0] d);
    bus.address = a;
    bus.writedata = d;
    bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a,
                    output logic [31:0] d);
    bus.address = a;
    @(posedge clk);
    #1 d = bus.readdata;
    @(negedge clk);
  endtask

  task automatic wait_rounds(input int n);
    int tgt;
    tgt = rounds + n;
    for (int i = 0; i < n * 400 && rounds < tgt; i++)
      @(negedge clk);
    chk("rounds_done", 32'(rounds >= tgt), 32'd1);
  endtask

  task automatic wait_ch2();
    seen_ch2 = 1'b0;
    for (int i = 0; i < 400 && !seen_ch2; i++)
      @(negedge clk);
    chk("ch2_seen", 32'(seen_ch2), 32'd1);
  endtask

  task automatic disable_idle();
    wr(3'd7, 32'd0);
    repeat (12) @(negedge clk);
  endtask

  task automatic chk_all(input string tag);
    logic [31:0] v;
    for (int i = 0; i < 6; i++) begin
      rd(3'(i), v);
      chk($sformatf("%s_res%0d", tag, i), v,
          (i < NCH) ? 32'(exp_res[i]) : 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    logic [11:0] old2;
    int n0;
    bit ovr_exp;

    bus.address = '0;
    bus.write = 1'b0;
    bus.writedata = '0;
    bus.adc_done = 1'b0;
    bus.adc_data = '0;
    for (int i = 0; i < NCH; i++) exp_res[i] = '0;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_start", 32'(bus.adc_start), 32'd0);
    chk("rst_ot", 32'(bus.overtemp), 32'd0);
    chk("rst_ch", 32'(bus.adc_ch), 32'd0);
    chk("rst_rdata", bus.readdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), v);
      chk($sformatf("rst_rd%0d", a), v,
          (a == 6 && OT) ? 32'hFFF : 32'd0);
    end

    // fixed samples 100,102,104,106 per channel
    mode = 1;
    lat = 1;
    smp_no = 0;
    wr(3'd7, 32'd1);
    #4 chk("start_lat1", 32'(bus.adc_start), 32'd0);
    @(negedge clk);
    #4 chk("start_lat2", 32'(bus.adc_start), 32'd1);
    @(negedge clk);
    wait_rounds(3);
    chk("period_l1", 32'(last_per), 32'(exp_period(1)));
    rd(3'd7, v);
    chk("stat_run", v, 32'h3);
    disable_idle();
    rd(3'd0, v);
    chk("avg_fixed", v, 32'd103);
    chk_all("fixed");

    // random samples
    mode = 0;
    lat = 2;
    wr(3'd7, 32'd1);
    wait_rounds(3);
    chk("period_l2", 32'(last_per), 32'(exp_period(2)));
    disable_idle();
    chk_all("rand");

    // overrun with a slow ADC, then recover and W1C
    lat = 3;
    ovr_exp = (exp_period(3) > PER);
    wr(3'd7, 32'd1);
    wait_rounds(3);
    chk("period_l3", 32'(last_per), 32'(exp_period(3)));
    rd(3'd7, v);
    chk("stat_ovr", v, ovr_exp ? 32'hB : 32'h3);
    lat = 1;
    wait_rounds(3);
    chk("period_back", 32'(last_per), 32'(exp_period(1)));
    wr(3'd7, 32'h9);
    rd(3'd7, v);
    chk("stat_w1c", v, 32'h3);
    disable_idle();
    chk_all("ovr");

    // disable while converting on channel 2
    lat = 5;
    wr(3'd7, 32'd1);
    wait_rounds(1);
    wait_ch2();
    old2 = exp_res[2];
    n0 = n_start;
    wr(3'd7, 32'h8);
    rd(3'd7, v);
    chk("stat_drain", v, 32'h2);
    repeat (10) @(negedge clk);
    chk("no_start", 32'(n_start), 32'(n0));
    rd(3'd7, v);
    chk("stat_idle", v, 32'h0);
    rd(3'd2, v);
    chk("keep_ch2", v, 32'(old2));
    chk_all("dis");

    // disable in the same cycle as adc_done
    lat = 1;
    wr(3'd7, 32'd1);
    wait_rounds(1);
    wait_ch2();
    old2 = exp_res[2];
    wr(3'd7, 32'd0);
    repeat (6) @(negedge clk);
    rd(3'd7, v);
    chk("stat_same", v, 32'h0);
    rd(3'd2, v);
    chk("keep_ch2b", v, 32'(old2));

    // stray adc_done while idle
    @(negedge clk);
    #2;
    bus.adc_done = 1'b1;
    bus.adc_data = 12'hABC;
    @(negedge clk);
    repeat (3) @(negedge clk);
    rd(3'd7, v);
    chk("stray_idle", v, 32'h0);
    chk_all("stray");

    // threshold and alarm
    wr(3'd6, 32'h200);
    rd(3'd6, v);
    chk("thr_rd", v, OT ? 32'h200 : 32'd0);
    mode = 2;
    wr(3'd7, 32'd1);
    wait_rounds(1);
    disable_idle();
    chk("ot_set", 32'(bus.overtemp), 32'(m_alarm));
    rd(3'd7, v);
    chk("stat_alarm", v, 32'(m_alarm) << 2);
    rd(3'd1, v);
    chk("res_ch1", v, 32'(exp_res[1]));
    wr(3'd7, 32'h4);
    repeat (2) @(negedge clk);
    chk("ot_clr", 32'(bus.overtemp), 32'(m_alarm));
    rd(3'd7, v);
    chk("stat_clr", v, 32'h0);
    chk_all("end");

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
